// File: rtl/div_seq.sv
// rtl/div_seq.sv - iterative RV32M divide sequencer (DIV/DIVU/REM/REMU), one quotient bit per clock
module div_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  stallreq_o
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ON, END} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH:0]   rem_r;
    logic [DATA_WIDTH-1:0] quo_r;
    logic [DATA_WIDTH-1:0] dsr_r;
    logic [DATA_WIDTH-1:0] result_r;
    logic                  op_rem;
    logic                  neg_q;
    logic                  neg_r;

    logic                  accept;
    logic                  div_zero;
    logic                  overflow;
    logic                  last_step;
    logic                  sgn_a;
    logic                  sgn_b;
    logic [DATA_WIDTH-1:0] abs_a;
    logic [DATA_WIDTH-1:0] abs_b;
    logic [DATA_WIDTH+1:0] shifted;
    logic [DATA_WIDTH+1:0] diff;
    logic [DATA_WIDTH:0]   rem_nxt;
    logic [DATA_WIDTH-1:0] quo_nxt;
    logic [DATA_WIDTH-1:0] q_fix;
    logic [DATA_WIDTH-1:0] r_fix;

    assign accept    = (state == IDLE) && start_i && !annul_i;
    assign div_zero  = (divisor_i == '0);
    assign overflow  = op_i[0] && (dividend_i == MIN_NEG) && (divisor_i == '1);
    assign last_step = (cnt == CW'(DATA_WIDTH-1));

    assign sgn_a = op_i[0] & dividend_i[DATA_WIDTH-1];
    assign sgn_b = op_i[0] & divisor_i[DATA_WIDTH-1];
    assign abs_a = sgn_a ? -dividend_i : dividend_i;
    assign abs_b = sgn_b ? -divisor_i : divisor_i;

    // Restoring step: shift in the next dividend bit, keep the difference unless it borrowed
    assign shifted = {rem_r, quo_r[DATA_WIDTH-1]};
    assign diff    = shifted - {2'b00, dsr_r};
    assign rem_nxt = diff[DATA_WIDTH+1] ? shifted[DATA_WIDTH:0] : diff[DATA_WIDTH:0];
    assign quo_nxt = {quo_r[DATA_WIDTH-2:0], ~diff[DATA_WIDTH+1]};

    assign q_fix = neg_q ? -quo_nxt : quo_nxt;
    assign r_fix = neg_r ? -rem_nxt[DATA_WIDTH-1:0] : rem_nxt[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (div_zero || overflow) ? END : ON;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_nxt = IDLE;
                end else if (last_step) begin
                    state_nxt = END;
                end
            end
            END:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            dsr_r    <= '0;
            result_r <= '0;
            op_rem   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_rem <= op_i[1];
                        if (div_zero) begin
                            result_r <= op_i[1] ? dividend_i : '1;
                        end else if (overflow) begin
                            result_r <= op_i[1] ? '0 : MIN_NEG;
                        end else begin
                            rem_r <= '0;
                            quo_r <= abs_a;
                            dsr_r <= abs_b;
                            cnt   <= '0;
                            neg_q <= sgn_a ^ sgn_b;
                            neg_r <= sgn_a;
                        end
                    end
                end
                ON: begin
                    if (!annul_i) begin
                        rem_r <= rem_nxt;
                        quo_r <= quo_nxt;
                        cnt   <= cnt + 1'b1;
                        if (last_step) begin
                            result_r <= op_rem ? r_fix : q_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o   = result_r;
    assign ready_o    = (state == END);
    assign busy_o     = (state != IDLE);
    assign stallreq_o = accept || (state == ON);

endmodule
